accum_alu_undo: RTL and testbench
=================================

// Module: accum_alu_undo
// PURPOSE
//  Parametrised button-driven accumulator ALU for the switch/7-seg demo tiles.
//  - Raw push-buttons: go and undo. Each is synchronised, debounced and edge-detected.
//  - Each accepted press applies one of 8 ops between acc and a zero-extended operand.
//  - Optional saturation on add/sub.
//  - A DEPTH-entry undo history restores prior acc values. acc drives display/io_out.
// PARAMETERS
//  ACC_W    8  accumulator width (>=4)
//  OPD_W    3  operand width (1..ACC_W)
//  DEPTH    4  undo history entries (>=1)
//  DEB_CYC  4  consecutive stable cycles to accept a button level change; 0 = no debounce
// PORTS
//  clock     in   1                   single clock; all state on posedge
//  reset     in   1                   synchronous, active-high; clears all state
//  go        in   1                   raw button: execute op on press
//  undo      in   1                   raw button: restore previous acc on press
//  operand   in   OPD_W               operand, zero-extended to ACC_W
//  op        in   3                   op select, sampled on the fire cycle
//  sat_en    in   1                   1 = saturate add/sub
//  acc       out  ACC_W               accumulator value
//  ovf       out  1                   carry/borrow of last executed op
//  hist_cnt  out  $clog2(DEPTH+1)     valid history entries
// BEHAVIOUR
//  Reset (sync): acc=0, ovf=0, hist_cnt=0, sync/debounce state=0.
//   - Debounced level = low, so a button held through reset fires once after release of reset.
//   - Reset overrides any pending press or counter.
//  Button path (identical for go/undo):
//   - 2-FF synchroniser.
//   - Counter increments while synced != stable and clears when equal; stable flips when counter reaches DEB_CYC.
//   - fire = 1-cycle pulse on stable 0->1. Holding a button fires once; pulses shorter than DEB_CYC cycles never fire.
//  Latency: raw go/undo high from edge n (held) -> acc/ovf/hist_cnt updated at edge n+DEB_CYC+3.
//  Ops (B = zero-extended operand):
//   000 ADD  acc+B;  ovf=carry out
//   001 SUB  acc-B;  ovf=borrow (B>acc)
//   010 XOR  acc^B;  ovf=0
//   011 SHL  acc<<B; B>=ACC_W -> 0; ovf=0
//   100 SHR  logical; B>=ACC_W -> 0; ovf=0
//   101 AND  acc&B;  ovf=0
//   110 OR   acc|B;  ovf=0
//   111 LOAD acc=B;  ovf=0
//  sat_en=1: ADD overflow -> all-ones, SUB borrow -> 0; ovf still reports 1. Other ops ignore sat_en.
//  go fire: push old acc to history, then update acc and ovf.
//   - History full -> oldest entry overwritten (circular); hist_cnt stays DEPTH.
//  undo fire: hist_cnt>0 -> acc=most recent entry, hist_cnt-1, ovf=0.
//   - hist_cnt==0 -> no state change.
//  go and undo fire in the same cycle: undo executes, go press discarded (not queued).
//  op/operand/sat_en are sampled only in the fire cycle; changes at other times have no effect.
// STRUCTURE
//  - Package accum_alu_pkg: op_e enum (ADD..LOAD, 3-bit encodings above); function alu_apply(acc, b, op, sat) -> {ovf, result}.
//  - Sub-module btn_debounce #(DEB_CYC): synchroniser + counter + rising-edge fire. Instantiated twice.
//  - History: DEPTH x ACC_W register array, head pointer (wraps mod DEPTH), count register.
// TESTING (defaults unless noted; "press" = hold >= DEB_CYC+3 cycles, then release)
//  1. LOAD 5, press go -> acc=5. ADD 3, hold go 50 cycles -> acc=8 exactly once. Latency = 7 cycles.
//  2. acc=0xFE, ADD 3, sat_en=0 -> acc=0x01, ovf=1. Repeat from 0xFE with sat_en=1 -> acc=0xFF, ovf=1.
//  3. acc=2, SUB 5 -> acc=0xFD, ovf=1. sat_en=1 -> acc=0x00, ovf=1. XOR 3 on 0x0F -> 0x0C, ovf=0.
//  4. acc=0x01, SHL 7 -> 0x80. SHR 7 -> 0x01. With OPD_W=4: SHL 9 -> 0x00.
//  5. Undo sequence: LOAD 1, ADD 1, ADD 1, ADD 1, ADD 1 (acc 1..5, hist_cnt=4).
//   - 4 undos -> acc 4,3,2,1.
//   - 5th undo -> acc=1, hist_cnt=0, unchanged.
//  6. Glitch/boundary cases:
//   - go high 3 cycles -> no change.
//   - go+undo pressed together -> only undo.
//   - reset asserted mid-debounce -> all outputs 0, no fire after reset.

Source files
------------

// File: rtl/accum_alu_pkg.sv
// Shared op encodings and the combinational ALU used by the accumulator tile.
// The ALU works on a fixed 32-bit datapath and masks the result to the caller's width.
package accum_alu_pkg;

   localparam int ALU_MAX_W = 32;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_XOR  = 3'b010,
      OP_SHL  = 3'b011,
      OP_SHR  = 3'b100,
      OP_AND  = 3'b101,
      OP_OR   = 3'b110,
      OP_LOAD = 3'b111
   } op_e;

   // Returns {ovf, result}; operands must already be zero-extended and below 2**width.
   function automatic logic [ALU_MAX_W:0] alu_apply(
      input logic [ALU_MAX_W-1:0] acc,
      input logic [ALU_MAX_W-1:0] b,
      input op_e                  op,
      input logic                 sat,
      input logic [5:0]           width
   );
      logic [ALU_MAX_W:0]   w_full;
      logic [ALU_MAX_W:0]   w_sum;
      logic [ALU_MAX_W-1:0] w_mask;
      logic [ALU_MAX_W-1:0] w_res;
      logic [ALU_MAX_W-1:0] w_wid;
      logic                 w_ovf;
      w_full = ((ALU_MAX_W+1)'(1) << width) - (ALU_MAX_W+1)'(1);
      w_mask = w_full[ALU_MAX_W-1:0];
      w_wid  = ALU_MAX_W'(width);
      w_sum  = {1'b0, acc} + {1'b0, b};
      w_res  = '0;
      w_ovf  = 1'b0;
      case (op)
         OP_ADD: begin
            w_ovf = w_sum[width];
            w_res = (w_ovf && sat) ? w_mask : (w_sum[ALU_MAX_W-1:0] & w_mask);
         end
         OP_SUB: begin
            w_ovf = (b > acc);
            w_res = (w_ovf && sat) ? '0 : ((acc - b) & w_mask);
         end
         OP_XOR:  w_res = acc ^ b;
         OP_SHL:  w_res = (b >= w_wid) ? '0 : ((acc << b) & w_mask);
         OP_SHR:  w_res = (b >= w_wid) ? '0 : (acc >> b);
         OP_AND:  w_res = acc & b;
         OP_OR:   w_res = acc | b;
         default: w_res = b;
      endcase
      return {w_ovf, w_res};
   endfunction

endpackage

// File: rtl/accum_alu_undo_btn_debounce.sv
// Raw push-button conditioner: 2-FF synchroniser, stability counter, registered press pulse.
// DEB_CYC = 0 bypasses the counter and treats the synchronised level as stable.
module btn_debounce #(
   parameter int DEB_CYC = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic i_btn,
   output logic o_fire
);

   logic r_sync1;
   logic r_sync2;
   logic r_prev;
   logic r_fire;
   logic w_stable;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
         r_fire  <= 1'b0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         r_prev  <= w_stable;
         r_fire  <= w_stable & ~r_prev;
      end
   end

   generate
      if (DEB_CYC == 0) begin : g_nodeb
         assign w_stable = r_sync2;
      end else begin : g_deb
         localparam int CNT_W = $clog2(DEB_CYC + 1);
         logic [CNT_W-1:0] r_cnt;
         logic             r_stable;
         // The flip lands on the DEB_CYC-th consecutive mismatching cycle.
         always_ff @(posedge clock) begin
            if (reset) begin
               r_cnt    <= '0;
               r_stable <= 1'b0;
            end else if (r_sync2 == r_stable) begin
               r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEB_CYC - 1)) begin
               r_cnt    <= '0;
               r_stable <= r_sync2;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
         assign w_stable = r_stable;
      end
   endgenerate

   assign o_fire = r_fire;

endmodule

// File: rtl/accum_alu_undo.sv
// Button-driven accumulator ALU with a circular undo history of previous acc values.
// ACC_W is limited to the 32-bit ALU datapath in accum_alu_pkg.
module accum_alu_undo
   import accum_alu_pkg::*;
#(
   parameter int ACC_W   = 8,
   parameter int OPD_W   = 3,
   parameter int DEPTH   = 4,
   parameter int DEB_CYC = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         go,
   input  logic                         undo,
   input  logic [OPD_W-1:0]             operand,
   input  logic [2:0]                   op,
   input  logic                         sat_en,
   output logic [ACC_W-1:0]             acc,
   output logic                         ovf,
   output logic [$clog2(DEPTH+1)-1:0]   hist_cnt
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic                 w_go_fire;
   logic                 w_undo_fire;
   logic [ALU_MAX_W:0]   w_alu;
   logic [ACC_W-1:0]     w_res;
   logic                 w_ovf;

   logic [ACC_W-1:0]     r_acc;
   logic                 r_ovf;
   logic [CNT_W-1:0]     r_cnt;
   logic [PTR_W-1:0]     r_head;
   logic [PTR_W-1:0]     w_head_nxt;
   logic [PTR_W-1:0]     w_head_prv;
   logic [ACC_W-1:0]     r_hist [DEPTH];

   btn_debounce #(.DEB_CYC(DEB_CYC)) u_go_btn (
      .clock  (clock),
      .reset  (reset),
      .i_btn  (go),
      .o_fire (w_go_fire)
   );

   btn_debounce #(.DEB_CYC(DEB_CYC)) u_undo_btn (
      .clock  (clock),
      .reset  (reset),
      .i_btn  (undo),
      .o_fire (w_undo_fire)
   );

   assign w_alu = alu_apply(ALU_MAX_W'(r_acc), ALU_MAX_W'(operand), op_e'(op), sat_en, 6'(ACC_W));
   assign w_res = w_alu[ACC_W-1:0];
   assign w_ovf = w_alu[ALU_MAX_W];

   generate
      if (ACC_W < ALU_MAX_W) begin : g_hi
         logic w_unused_hi;
         assign w_unused_hi = &{1'b0, w_alu[ALU_MAX_W-1:ACC_W]};
      end
   endgenerate

   // r_head is the next slot to write; the newest entry sits just behind it.
   assign w_head_nxt = (r_head == PTR_W'(DEPTH - 1)) ? '0 : r_head + PTR_W'(1);
   assign w_head_prv = (r_head == '0) ? PTR_W'(DEPTH - 1) : r_head - PTR_W'(1);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_acc  <= '0;
         r_ovf  <= 1'b0;
         r_cnt  <= '0;
         r_head <= '0;
         for (int i = 0; i < DEPTH; i++) r_hist[i] <= '0;
      end else if (w_undo_fire) begin
         // A simultaneous go press is dropped, not queued.
         if (r_cnt != '0) begin
            r_acc  <= r_hist[w_head_prv];
            r_head <= w_head_prv;
            r_cnt  <= r_cnt - CNT_W'(1);
            r_ovf  <= 1'b0;
         end
      end else if (w_go_fire) begin
         r_hist[r_head] <= r_acc;
         r_head         <= w_head_nxt;
         if (r_cnt != CNT_W'(DEPTH)) r_cnt <= r_cnt + CNT_W'(1);
         r_acc <= w_res;
         r_ovf <= w_ovf;
      end
   end

   assign acc      = r_acc;
   assign ovf      = r_ovf;
   assign hist_cnt = r_cnt;

endmodule

// File: tb/tb_accum_alu_undo.sv
// Bench for accum_alu_undo: directed op table, undo/glitch/reset sequences, and
// randomized presses checked against a queue-based model of the accumulator.
module tb_accum_alu_undo;

   localparam int ACC_W = 8;
   localparam int OPD_W = 3;
   localparam int DEPTH = 4;
   localparam int DEB   = 4;

   logic                        clock = 1'b0;
   logic                        reset;
   logic                        go, undo, sat_en;
   logic [2:0]                  op;
   logic [OPD_W-1:0]            operand;
   logic [ACC_W-1:0]            acc;
   logic                        ovf;
   logic [$clog2(DEPTH+1)-1:0]  hist_cnt;

   logic                        go2, undo2, sat2;
   logic [2:0]                  op2;
   logic [3:0]                  operand2;
   logic [ACC_W-1:0]            acc2;
   logic                        ovf2;
   logic [$clog2(DEPTH+1)-1:0]  hist2;

   int checks = 0;
   int errors = 0;

   int m_acc, m_ovf;
   int m_hist [$];

   typedef struct {
      int op;
      int opd;
      int sat;
      int acc;
      int ovf;
   } vec_t;
   vec_t tbl [22];

   always #5 clock = ~clock;

   accum_alu_undo #(.ACC_W(ACC_W), .OPD_W(OPD_W), .DEPTH(DEPTH), .DEB_CYC(DEB)) u_dut (
      .clock(clock), .reset(reset), .go(go), .undo(undo), .operand(operand), .op(op),
      .sat_en(sat_en), .acc(acc), .ovf(ovf), .hist_cnt(hist_cnt)
   );

   accum_alu_undo #(.ACC_W(ACC_W), .OPD_W(4), .DEPTH(DEPTH), .DEB_CYC(0)) u_dut4 (
      .clock(clock), .reset(reset), .go(go2), .undo(undo2), .operand(operand2), .op(op2),
      .sat_en(sat2), .acc(acc2), .ovf(ovf2), .hist_cnt(hist2)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1; go = 1'b0; undo = 1'b0; go2 = 1'b0;
      cyc(2);
      reset = 1'b0;
      cyc(1);
      m_acc = 0; m_ovf = 0; m_hist.delete();
   endtask

   // Hold the button(s) long enough to fire, then scramble op inputs once the fire cycle is past.
   task automatic press(input int g, input int u, input int o, input int b, input int s);
      @(negedge clock);
      op = o[2:0]; operand = b[OPD_W-1:0]; sat_en = s[0]; go = g[0]; undo = u[0];
      cyc(DEB + 3);
      go = 1'b0; undo = 1'b0;
      cyc(1);
      op = 3'($urandom); operand = OPD_W'($urandom); sat_en = 1'($urandom);
      cyc(DEB + 3);
   endtask

   task automatic press2(input int o, input int b);
      @(negedge clock);
      op2 = o[2:0]; operand2 = b[3:0]; sat2 = 1'b0; go2 = 1'b1;
      cyc(3);
      go2 = 1'b0;
      cyc(4);
   endtask

   task automatic model_go(input int o, input int b, input int s);
      int r, v;
      m_hist.push_back(m_acc);
      if (m_hist.size() > DEPTH) m_hist.delete(0);
      v = 0;
      case (o)
         0: begin r = m_acc + b; if (r > 255) begin v = 1; r = (s != 0) ? 255 : r - 256; end end
         1: begin r = m_acc - b; if (r < 0) begin v = 1; r = (s != 0) ? 0 : r + 256; end end
         2: r = m_acc ^ b;
         3: r = (b >= ACC_W) ? 0 : (m_acc * (1 << b)) % 256;
         4: r = (b >= ACC_W) ? 0 : m_acc / (1 << b);
         5: r = m_acc & b;
         6: r = m_acc | b;
         default: r = b;
      endcase
      m_acc = r; m_ovf = v;
   endtask

   task automatic model_undo();
      if (m_hist.size() > 0) begin
         m_acc = m_hist[m_hist.size() - 1];
         m_hist.delete(m_hist.size() - 1);
         m_ovf = 0;
      end
   endtask

   initial begin
      int lat, changes, prev, k;
      int kind, o, b, s;

      tbl[0]  = '{7, 5, 0, 'h05, 0};  tbl[1]  = '{0, 3, 0, 'h08, 0};
      tbl[2]  = '{7, 0, 0, 'h00, 0};  tbl[3]  = '{1, 2, 0, 'hFE, 1};
      tbl[4]  = '{0, 3, 0, 'h01, 1};  tbl[5]  = '{7, 0, 0, 'h00, 0};
      tbl[6]  = '{1, 2, 0, 'hFE, 1};  tbl[7]  = '{0, 3, 1, 'hFF, 1};
      tbl[8]  = '{7, 2, 0, 'h02, 0};  tbl[9]  = '{1, 5, 0, 'hFD, 1};
      tbl[10] = '{7, 2, 0, 'h02, 0};  tbl[11] = '{1, 5, 1, 'h00, 1};
      tbl[12] = '{7, 7, 0, 'h07, 0};  tbl[13] = '{3, 1, 0, 'h0E, 0};
      tbl[14] = '{6, 1, 0, 'h0F, 0};  tbl[15] = '{2, 3, 0, 'h0C, 0};
      tbl[16] = '{7, 1, 0, 'h01, 0};  tbl[17] = '{3, 7, 0, 'h80, 0};
      tbl[18] = '{4, 7, 0, 'h01, 0};  tbl[19] = '{5, 6, 0, 'h00, 0};
      tbl[20] = '{0, 7, 1, 'h07, 0};  tbl[21] = '{4, 0, 0, 'h07, 0};

      reset = 1'b1; go = 1'b0; undo = 1'b0; sat_en = 1'b0; op = '0; operand = '0;
      go2 = 1'b0; undo2 = 1'b0; sat2 = 1'b0; op2 = '0; operand2 = '0;
      cyc(3);
      chk("rst_acc", int'(acc), 0);
      chk("rst_ovf", int'(ovf), 0);
      chk("rst_hist", int'(hist_cnt), 0);
      chk("rst_acc2", int'(acc2), 0);
      reset = 1'b0;
      cyc(2);

      // Latency and hold-fires-once
      press(1, 0, 7, 5, 0);
      chk("load5", int'(acc), 5);
      @(negedge clock);
      op = 3'd0; operand = 3'd3; sat_en = 1'b0; go = 1'b1;
      lat = -1; changes = 0; prev = int'(acc);
      for (k = 1; k <= 50; k++) begin
         @(negedge clock);
         if (int'(acc) != prev) begin
            changes++;
            if (lat < 0) lat = k - 1;
            prev = int'(acc);
         end
      end
      go = 1'b0;
      cyc(DEB + 4);
      chk("latency", lat, DEB + 3);
      chk("hold_once", changes, 1);
      chk("add3", int'(acc), 8);

      // Directed op table
      do_reset();
      for (int i = 0; i < 22; i++) begin
         press(1, 0, tbl[i].op, tbl[i].opd, tbl[i].sat);
         chk($sformatf("tbl%0d_acc", i), int'(acc), tbl[i].acc);
         chk($sformatf("tbl%0d_ovf", i), int'(ovf), tbl[i].ovf);
         chk($sformatf("tbl%0d_hist", i), int'(hist_cnt), (i + 1 < DEPTH) ? i + 1 : DEPTH);
      end

      // Undo history
      do_reset();
      press(1, 0, 7, 1, 0);
      for (int i = 0; i < 4; i++) press(1, 0, 0, 1, 0);
      chk("undo_pre_acc", int'(acc), 5);
      chk("undo_pre_hist", int'(hist_cnt), 4);
      for (int i = 0; i < 4; i++) begin
         press(0, 1, 0, 0, 0);
         chk($sformatf("undo%0d_acc", i), int'(acc), 4 - i);
         chk($sformatf("undo%0d_hist", i), int'(hist_cnt), 3 - i);
         chk($sformatf("undo%0d_ovf", i), int'(ovf), 0);
      end
      press(0, 1, 0, 0, 0);
      chk("undo_empty_acc", int'(acc), 1);
      chk("undo_empty_hist", int'(hist_cnt), 0);

      // Short glitch never fires
      @(negedge clock);
      op = 3'd7; operand = 3'd6; go = 1'b1;
      cyc(3);
      go = 1'b0;
      cyc(DEB + 6);
      chk("glitch_acc", int'(acc), 1);
      chk("glitch_hist", int'(hist_cnt), 0);

      // go+undo together -> undo only
      press(1, 0, 7, 6, 0);
      chk("both_pre", int'(acc), 6);
      press(1, 1, 7, 3, 0);
      chk("both_acc", int'(acc), 1);
      chk("both_hist", int'(hist_cnt), 0);

      // Reset mid-debounce
      press(1, 0, 7, 5, 0);
      @(negedge clock);
      op = 3'd7; operand = 3'd2; go = 1'b1;
      cyc(4);
      reset = 1'b1; go = 1'b0;
      cyc(2);
      reset = 1'b0;
      cyc(20);
      chk("midrst_acc", int'(acc), 0);
      chk("midrst_ovf", int'(ovf), 0);
      chk("midrst_hist", int'(hist_cnt), 0);

      // Held through reset fires once after release
      @(negedge clock);
      reset = 1'b1; go = 1'b1; op = 3'd7; operand = 3'd6;
      cyc(3);
      reset = 1'b0;
      cyc(20);
      chk("heldrst_acc", int'(acc), 6);
      chk("heldrst_hist", int'(hist_cnt), 1);
      cyc(20);
      chk("heldrst_once", int'(hist_cnt), 1);
      go = 1'b0;
      cyc(10);

      // OPD_W=4, no-debounce instance
      @(negedge clock);
      op2 = 3'd7; operand2 = 4'd1; go2 = 1'b1;
      lat = -1;
      for (k = 1; k <= 10; k++) begin
         @(negedge clock);
         if (lat < 0 && acc2 == 8'd1) lat = k - 1;
      end
      go2 = 1'b0;
      cyc(4);
      chk("d4_latency", lat, 3);
      press2(3, 9);
      chk("d4_shl9", int'(acc2), 0);
      chk("d4_shl9_ovf", int'(ovf2), 0);
      press2(7, 15);
      chk("d4_load15", int'(acc2), 15);
      press2(4, 8);
      chk("d4_shr8", int'(acc2), 0);
      press2(7, 3);
      press2(3, 2);
      chk("d4_shl2", int'(acc2), 12);
      chk("d4_hist", int'(hist2), 4);

      // Randomized against the model
      do_reset();
      for (int i = 0; i < 300; i++) begin
         kind = $urandom_range(0, 9);
         o = $urandom_range(0, 7);
         b = $urandom_range(0, 7);
         s = $urandom_range(0, 1);
         if (kind <= 6) begin
            press(1, 0, o, b, s);
            model_go(o, b, s);
         end else begin
            press(kind == 9 ? 1 : 0, 1, o, b, s);
            model_undo();
         end
         chk($sformatf("rnd%0d_acc", i), int'(acc), m_acc);
         chk($sformatf("rnd%0d_ovf", i), int'(ovf), m_ovf);
         chk($sformatf("rnd%0d_hist", i), int'(hist_cnt), m_hist.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
